// File: rtl/pktctrl_pkg.sv
// Shared packet-control definitions: lane geometry and the MDIO readback FSM states.
package pktctrl_pkg;

    localparam int unsigned PKT_LANE_W    = 9;
    localparam int unsigned PKT_LANES     = 96;
    localparam int unsigned LANE_LIMIT_48 = 48;
    localparam int unsigned LANE_LIMIT_96 = 96;
    localparam int unsigned SEL_W         = 7;
    localparam int unsigned DROP_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT,
        ST_STRB
    } rd_state_e;

endpackage

// File: rtl/mdio_lane_mux.sv
// Combinational lane extractor: picks one LANE_W slice of a wide word and flags
// indices beyond the active lane count (48 or 96).
module mdio_lane_mux
    import pktctrl_pkg::*;
#(
    parameter int unsigned LANES  = PKT_LANES,
    parameter int unsigned LANE_W = PKT_LANE_W
) (
    input  logic [LANES*LANE_W-1:0] word,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    en96,
    output logic [LANE_W-1:0]       lane_c,
    output logic                    in_range_c
);

    logic [SEL_W-1:0] limit;

    always_comb begin
        limit      = en96 ? SEL_W'(LANE_LIMIT_96) : SEL_W'(LANE_LIMIT_48);
        in_range_c = (sel < limit) && (32'(sel) < LANES);
        lane_c     = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (32'(sel) == k) begin
                lane_c = word[k*LANE_W +: LANE_W];
            end
        end
        // Out-of-range lanes read as zero.
        if (!in_range_c) begin
            lane_c = '0;
        end
    end

endmodule

// File: rtl/mdio_mem_rdback.sv
// MDIO-initiated single-lane readback from the capture memory, with a one-deep
// request slot, busy arbitration and a stretched completion strobe.
module mdio_mem_rdback
    import pktctrl_pkg::*;
#(
    parameter int unsigned LANES   = PKT_LANES,
    parameter int unsigned LANE_W  = PKT_LANE_W,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned STRETCH = 4
) (
    input  logic                    pktctrl_clk,
    input  logic                    pktctrl_rstn,
    input  logic                    rf_mdio_read_pulse_sync,
    input  logic [ADDR_W-1:0]       rf_mdio_memory_addr_sync,
    input  logic [SEL_W-1:0]        rf_mdio_data_sel_sync,
    input  logic                    rf_96path_en_sync,
    input  logic                    cap_busy,
    output logic                    mem_ce,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [LANES*LANE_W-1:0] mem_rdata,
    output logic [LANE_W-1:0]       rf_mdio_pkt_data,
    output logic                    mdio_read_pulse_r,
    output logic [DROP_W-1:0]       rd_drop_cnt,
    output logic                    rd_sel_err
);

    localparam int unsigned CNT_W = 4;

    rd_state_e         state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              req_q;
    logic              req_edge_c;

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_n;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_n;
    logic              cur_en96_q, cur_en96_n;

    logic              slot_vld_q, slot_vld_n;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_n;
    logic [SEL_W-1:0]  slot_sel_q, slot_sel_n;
    logic              slot_en96_q, slot_en96_n;

    logic              mem_ce_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [LANE_W-1:0] pkt_data_n;
    logic              strobe_n;
    logic [DROP_W-1:0] drop_n;
    logic              sel_err_n;

    logic [LANE_W-1:0] lane_c;
    logic              in_range_c;

    assign req_edge_c = rf_mdio_read_pulse_sync & ~req_q;

    mdio_lane_mux #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_mux (
        .word       (mem_rdata),
        .sel        (cur_sel_q),
        .en96       (cur_en96_q),
        .lane_c     (lane_c),
        .in_range_c (in_range_c)
    );

    // Next-state, slot bookkeeping and registered-output values.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        cur_addr_n  = cur_addr_q;
        cur_sel_n   = cur_sel_q;
        cur_en96_n  = cur_en96_q;
        slot_vld_n  = slot_vld_q;
        slot_addr_n = slot_addr_q;
        slot_sel_n  = slot_sel_q;
        slot_en96_n = slot_en96_q;
        mem_ce_n    = 1'b0;
        mem_addr_n  = mem_addr;
        pkt_data_n  = rf_mdio_pkt_data;
        strobe_n    = mdio_read_pulse_r;
        drop_n      = rd_drop_cnt;
        sel_err_n   = rd_sel_err;

        // Edges while a read is in flight park in the slot; a second one is dropped.
        if (req_edge_c && (state_q != ST_IDLE)) begin
            if (!slot_vld_q) begin
                slot_vld_n  = 1'b1;
                slot_addr_n = rf_mdio_memory_addr_sync;
                slot_sel_n  = rf_mdio_data_sel_sync;
                slot_en96_n = rf_96path_en_sync;
            end else if (rd_drop_cnt != {DROP_W{1'b1}}) begin
                drop_n = rd_drop_cnt + DROP_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (slot_vld_q) begin
                    cur_addr_n  = slot_addr_q;
                    cur_sel_n   = slot_sel_q;
                    cur_en96_n  = slot_en96_q;
                    slot_vld_n  = req_edge_c;
                    slot_addr_n = rf_mdio_memory_addr_sync;
                    slot_sel_n  = rf_mdio_data_sel_sync;
                    slot_en96_n = rf_96path_en_sync;
                    state_n     = ST_ARB;
                end else if (req_edge_c) begin
                    cur_addr_n = rf_mdio_memory_addr_sync;
                    cur_sel_n  = rf_mdio_data_sel_sync;
                    cur_en96_n = rf_96path_en_sync;
                    state_n    = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!cap_busy) begin
                    mem_ce_n   = 1'b1;
                    mem_addr_n = cur_addr_q;
                    cnt_n      = '0;
                    state_n    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    pkt_data_n = lane_c;
                    sel_err_n  = rd_sel_err | ~in_range_c;
                    strobe_n   = 1'b1;
                    cnt_n      = '0;
                    state_n    = ST_STRB;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_STRB: begin
                if (cnt_q == CNT_W'(STRETCH - 1)) begin
                    strobe_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            req_q             <= 1'b0;
            cur_addr_q        <= '0;
            cur_sel_q         <= '0;
            cur_en96_q        <= 1'b0;
            slot_vld_q        <= 1'b0;
            slot_addr_q       <= '0;
            slot_sel_q        <= '0;
            slot_en96_q       <= 1'b0;
            mem_ce            <= 1'b0;
            mem_addr          <= '0;
            rf_mdio_pkt_data  <= '0;
            mdio_read_pulse_r <= 1'b0;
            rd_drop_cnt       <= '0;
            rd_sel_err        <= 1'b0;
        end else begin
            state_q           <= state_n;
            cnt_q             <= cnt_n;
            req_q             <= rf_mdio_read_pulse_sync;
            cur_addr_q        <= cur_addr_n;
            cur_sel_q         <= cur_sel_n;
            cur_en96_q        <= cur_en96_n;
            slot_vld_q        <= slot_vld_n;
            slot_addr_q       <= slot_addr_n;
            slot_sel_q        <= slot_sel_n;
            slot_en96_q       <= slot_en96_n;
            mem_ce            <= mem_ce_n;
            mem_addr          <= mem_addr_n;
            rf_mdio_pkt_data  <= pkt_data_n;
            mdio_read_pulse_r <= strobe_n;
            rd_drop_cnt       <= drop_n;
            rd_sel_err        <= sel_err_n;
        end
    end

endmodule

// File: tb/tb_mdio_mem_rdback.sv
// Self-checking bench for mdio_mem_rdback: directed scenarios plus randomized reads
// compared against an event-level reference model of the readback service.
module tb_mdio_mem_rdback;

    localparam int unsigned LANES   = 96;
    localparam int unsigned LANE_W  = 9;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned STRETCH = 4;
    localparam int unsigned WW      = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pulse;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        sel;
    logic              en96;
    logic              busy;
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [WW-1:0]     mem_rdata;
    logic [LANE_W-1:0] pkt;
    logic              strobe;
    logic [7:0]        drop;
    logic              err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    int seed  = 0;
    logic exp_err = 1'b0;

    mdio_mem_rdback #(
        .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STRETCH(STRETCH)
    ) dut (
        .pktctrl_clk              (clk),
        .pktctrl_rstn             (rst_n),
        .rf_mdio_read_pulse_sync  (pulse),
        .rf_mdio_memory_addr_sync (addr),
        .rf_mdio_data_sel_sync    (sel),
        .rf_96path_en_sync        (en96),
        .cap_busy                 (busy),
        .mem_ce                   (mem_ce),
        .mem_addr                 (mem_addr),
        .mem_rdata                (mem_rdata),
        .rf_mdio_pkt_data         (pkt),
        .mdio_read_pulse_r        (strobe),
        .rd_drop_cnt              (drop),
        .rd_sel_err               (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as a pure function of address and lane.
    function automatic logic [LANE_W-1:0] lane_val(input logic [ADDR_W-1:0] a, input int k);
        if (mode == 0) return LANE_W'(k + 3);
        return LANE_W'(int'(a) * 7 + k * 13 + seed);
    endfunction

    function automatic logic [WW-1:0] mk_word(input logic [ADDR_W-1:0] a);
        logic [WW-1:0] w;
        for (int k = 0; k < int'(LANES); k++) w[k*LANE_W +: LANE_W] = lane_val(a, k);
        return w;
    endfunction

    function automatic logic [LANE_W-1:0] exp_lane(input logic [ADDR_W-1:0] a, input logic [6:0] s,
                                                    input logic e);
        int lim;
        lim = e ? 96 : 48;
        if (int'(s) < lim) return lane_val(a, int'(s));
        return '0;
    endfunction

    // Memory with MEM_LAT read latency; junk on the bus outside the valid cycle.
    logic              lat_v [MEM_LAT];
    logic [ADDR_W-1:0] lat_a [MEM_LAT];
    logic [WW-1:0]     junk;

    always @(posedge clk) begin
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
            lat_v[i] <= lat_v[i-1];
            lat_a[i] <= lat_a[i-1];
        end
        lat_v[0] <= mem_ce;
        lat_a[0] <= mem_addr;
        for (int j = 0; j < int'(WW / 32); j++) junk[j*32 +: 32] <= $urandom;
    end

    always_comb begin
        mem_rdata = junk;
        if (lat_v[MEM_LAT-1] === 1'b1) mem_rdata = mk_word(lat_a[MEM_LAT-1]);
    end

    // Event monitor: read enables and strobe pulses.
    int                ce_cyc_q[$];
    logic [ADDR_W-1:0] ce_addr_q[$];
    int                rise_q[$];
    logic [LANE_W-1:0] rdata_q[$];
    int                len_q[$];
    logic              strobe_prev = 1'b0;
    int                run = 0;

    always @(negedge clk) begin
        if (mem_ce === 1'b1) begin
            ce_cyc_q.push_back(cyc);
            ce_addr_q.push_back(mem_addr);
        end
        if (strobe === 1'b1) begin
            if (!strobe_prev) begin
                rise_q.push_back(cyc);
                rdata_q.push_back(pkt);
                run = 1;
            end else begin
                run++;
            end
        end else if (strobe_prev) begin
            len_q.push_back(run);
        end
        strobe_prev = (strobe === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        ce_cyc_q.delete(); ce_addr_q.delete(); rise_q.delete(); rdata_q.delete(); len_q.delete();
    endtask

    task automatic req(input logic [ADDR_W-1:0] a, input logic [6:0] s, input logic e, output int n);
        addr  = a;
        sel   = s;
        en96  = e;
        pulse = 1'b1;
        n     = cyc;
        tick(1);
        pulse = 1'b0;
        addr  = ADDR_W'($urandom);
        sel   = 7'($urandom);
        en96  = 1'($urandom);
    endtask

    // Waits for one completed strobe, then checks it against the model.
    task automatic check_one(input string tag, input logic [ADDR_W-1:0] a, input logic [6:0] s,
                             input logic e, input int ce_exp);
        int k;
        int cc, rc, ln;
        logic [ADDR_W-1:0] ca;
        logic [LANE_W-1:0] d;
        k = 0;
        while (len_q.size() < 1 && k < 500) begin
            tick(1);
            k++;
        end
        if (ce_addr_q.size() == 0 || len_q.size() == 0 || rise_q.size() == 0) begin
            chk({tag, "_events"}, 32'(ce_addr_q.size() * 100 + len_q.size()), 32'(101));
            return;
        end
        ca = ce_addr_q.pop_front();
        cc = ce_cyc_q.pop_front();
        rc = rise_q.pop_front();
        d  = rdata_q.pop_front();
        ln = len_q.pop_front();
        chk({tag, "_addr"}, 32'(ca), 32'(a));
        chk({tag, "_ce_cyc"}, 32'(cc), 32'(ce_exp));
        chk({tag, "_rise_cyc"}, 32'(rc), 32'(ce_exp + int'(MEM_LAT) + 1));
        chk({tag, "_data"}, 32'(d), 32'(exp_lane(a, s, e)));
        chk({tag, "_len"}, 32'(ln), 32'(STRETCH));
        exp_err = exp_err | (int'(s) >= (e ? 96 : 48));
        chk({tag, "_sel_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b, d;
        logic [ADDR_W-1:0] a0, a1, a2;
        logic [6:0] s0, s1, s2;

        rst_n = 1'b0; pulse = 1'b0; addr = '0; sel = '0; en96 = 1'b1; busy = 1'b0;
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            lat_v[i] = 1'b0;
            lat_a[i] = '0;
        end
        tick(3);
        chk("rst_mem_ce", 32'(mem_ce), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_pkt", 32'(pkt), 0);
        chk("rst_strobe", 32'(strobe), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick(2);

        // Basic read with lane k = k+3.
        mode = 0;
        clear_q();
        req(15'h1234, 7'd5, 1'b1, n);
        check_one("basic", 15'h1234, 7'd5, 1'b1, n + 2);
        chk("basic_data_const", 32'(pkt), 32'd8);

        // Busy hold: no read issued until cap_busy falls.
        busy = 1'b1;
        req(15'h0ABC, 7'd95, 1'b1, n);
        tick(19);
        chk("busy_no_ce", 32'(ce_addr_q.size()), 0);
        busy = 1'b0;
        b = cyc;
        check_one("busy", 15'h0ABC, 7'd95, 1'b1, b + 1);
        chk("busy_data_const", 32'(pkt), 32'd98);

        // Range boundaries and capture-time sampling of the 96-path enable.
        req(15'h0100, 7'd60, 1'b0, n);
        check_one("range60_48", 15'h0100, 7'd60, 1'b0, n + 2);
        tick(2);
        req(15'h0101, 7'd47, 1'b0, n);
        check_one("range47_48", 15'h0101, 7'd47, 1'b0, n + 2);
        tick(2);
        req(15'h0102, 7'd60, 1'b1, n);
        check_one("range60_96", 15'h0102, 7'd60, 1'b1, n + 2);
        tick(2);
        req(15'h0103, 7'd96, 1'b1, n);
        check_one("range96_96", 15'h0103, 7'd96, 1'b1, n + 2);
        tick(2);

        // Back-to-back: second served from the slot, third dropped.
        mode = 1;
        seed = int'($urandom_range(0, 4095));
        a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom); a2 = ADDR_W'($urandom);
        s0 = 7'($urandom_range(0, 95)); s1 = 7'($urandom_range(0, 95)); s2 = 7'($urandom_range(0, 95));
        clear_q();
        req(a0, s0, 1'b1, n);
        tick(1);
        req(a1, s1, 1'b1, b);
        tick(1);
        req(a2, s2, 1'b1, b);
        check_one("b2b_first", a0, s0, 1'b1, n + 2);
        check_one("b2b_second", a1, s1, 1'b1, n + 2 + int'(MEM_LAT + STRETCH) + 3);
        tick(10);
        chk("b2b_third_dropped", 32'(ce_addr_q.size()), 0);
        chk("b2b_drop_cnt", 32'(drop), 1);

        // Saturation: hold the first read in arbitration, fill the slot, then flood.
        busy = 1'b1;
        a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
        s0 = 7'($urandom_range(0, 95)); s1 = 7'($urandom_range(0, 47));
        req(a0, s0, 1'b1, n);
        tick(1);
        req(a1, s1, 1'b0, n);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            req(ADDR_W'($urandom), 7'($urandom), 1'b1, n);
        end
        busy = 1'b0;
        b = cyc;
        check_one("sat_first", a0, s0, 1'b1, b + 1);
        check_one("sat_slot", a1, s1, 1'b0, b + 1 + int'(MEM_LAT + STRETCH) + 3);
        chk("sat_drop_cnt", 32'(drop), 255);
        tick(3);

        // Reset in WAIT aborts immediately and leaves no stale strobe.
        clear_q();
        req(ADDR_W'($urandom), 7'($urandom_range(0, 95)), 1'b1, n);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_ce", 32'(mem_ce), 0);
        chk("rstmid_mem_addr", 32'(mem_addr), 0);
        chk("rstmid_pkt", 32'(pkt), 0);
        chk("rstmid_strobe", 32'(strobe), 0);
        chk("rstmid_drop", 32'(drop), 0);
        chk("rstmid_err", 32'(err), 0);
        exp_err = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_q();
        tick(20);
        chk("rstmid_no_ce", 32'(ce_addr_q.size()), 0);
        chk("rstmid_no_strobe", 32'(rise_q.size()), 0);
        a0 = ADDR_W'($urandom); s0 = 7'($urandom_range(0, 47));
        req(a0, s0, 1'b0, n);
        check_one("rstmid_fresh", a0, s0, 1'b0, n + 2);

        // Level held high yields a single read.
        tick(2);
        clear_q();
        a0 = ADDR_W'($urandom); s0 = 7'($urandom_range(0, 95));
        addr = a0; sel = s0; en96 = 1'b1; pulse = 1'b1;
        n = cyc;
        tick(50);
        pulse = 1'b0;
        check_one("level", a0, s0, 1'b1, n + 2);
        tick(20);
        chk("level_extra_ce", 32'(ce_addr_q.size()), 0);
        chk("level_extra_strobe", 32'(rise_q.size()), 0);

        // Randomized isolated reads with random busy windows.
        for (int it = 0; it < 25; it++) begin
            a0 = ADDR_W'($urandom);
            s0 = 7'($urandom_range(0, 127));
            en96 = 1'b0;
            d = int'($urandom_range(0, 6));
            seed = int'($urandom_range(0, 4095));
            clear_q();
            if (d > 0) busy = 1'b1;
            req(a0, s0, 1'($urandom_range(0, 1)), n);
            s1 = s0;
            b = (d > 1) ? d : 1;
            if (d > 1) tick(d - 1);
            busy = 1'b0;
            check_one($sformatf("rnd%0d", it), a0, s1, dut.cur_en96_q, n + b + 1);
            tick(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
